// File: rtl/xpu_vpu_pc_tn_vlsu_dcq_ctrl_pkg.sv
// Shared constants for the VLSU data commit queue controller.
package xpu_vpu_pc_tn_vlsu_dcq_ctrl_pkg;

  localparam int XPU_VPU_PC_TN_VLSU_DCQ_DEPTH  = 8;
  localparam int XPU_VPU_PC_TN_VLSU_DCQ_PTR_W  = $clog2(XPU_VPU_PC_TN_VLSU_DCQ_DEPTH);
  localparam int XPU_VPU_PC_TN_VLSU_DCQ_PERF_W = 16;

endpackage

// File: rtl/xpu_vpu_pc_tn_vlsu_dcq_ptr.sv
// Wrap-bit queue pointer: PTR_W index bits plus one wrap MSB, with increment and clear.
module xpu_vpu_pc_tn_vlsu_dcq_ptr #(
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W:0]   ptr
);

  logic [PTR_W:0] r_ptr;

  // Pointer register; reset dominates clear, clear dominates increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= {(PTR_W+1){1'b0}};
    end else if (clr) begin
      r_ptr <= {(PTR_W+1){1'b0}};
    end else if (inc) begin
      r_ptr <= r_ptr + {{PTR_W{1'b0}}, 1'b1};
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/xpu_vpu_pc_tn_vlsu_dcq_ctrl.sv
// DCQ allocation / in-order release controller.
// Optional perf counter output enabled by XPU_VPU_PC_TN_VLSU_DCQ_PERF_EN.
module xpu_vpu_pc_tn_vlsu_dcq_ctrl
  import xpu_vpu_pc_tn_vlsu_dcq_ctrl_pkg::*;
#(
  parameter int DEPTH = XPU_VPU_PC_TN_VLSU_DCQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               vv_dcq_clk,
  input  logic               cpurst,
  input  logic               giu_xx_async_flush,
  input  logic               crt_req_vld,
  input  logic               crt_req_no_wb,
  input  logic               crt_req_op_last,
  output logic               crt_req_rdy,
  output logic [PTR_W-1:0]   crt_req_ptr,
  output logic [DEPTH-1:0]   dcq_entry_crt_vld_x,
  output logic [DEPTH-1:0]   dcq_entry_rls_vld_x,
  input  logic               wb_done_vld,
  input  logic [PTR_W-1:0]   wb_done_ptr,
  output logic               dcq_retire_vld,
  output logic [PTR_W-1:0]   dcq_retire_ptr,
  output logic               dcq_retire_op_last,
  input  logic               dcq_retire_rdy,
  output logic               dcq_full,
  output logic               dcq_empty,
  output logic [PTR_W:0]     dcq_cnt
`ifdef XPU_VPU_PC_TN_VLSU_DCQ_PERF_EN
  ,
  output logic [XPU_VPU_PC_TN_VLSU_DCQ_PERF_W-1:0] dcq_perf_full_stall_cnt
`endif
);

  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_done;
  logic [DEPTH-1:0] r_op_last;

  logic [PTR_W:0]   w_wr_ptr;
  logic [PTR_W:0]   w_rd_ptr;
  logic [PTR_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_rd_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_crt_rdy;
  logic             w_crt_fire;
  logic             w_ret_vld;
  logic             w_ret_fire;
  logic [DEPTH-1:0] w_one;
  logic [DEPTH-1:0] w_crt_oh;
  logic [DEPTH-1:0] w_rls_oh;
  logic [DEPTH-1:0] w_wb_oh;

  assign w_wr_idx   = w_wr_ptr[PTR_W-1:0];
  assign w_rd_idx   = w_rd_ptr[PTR_W-1:0];
  assign w_empty    = (w_wr_ptr == w_rd_ptr);
  assign w_full     = (w_wr_idx == w_rd_idx) && (w_wr_ptr[PTR_W] != w_rd_ptr[PTR_W]);

  // Full is taken from registered pointers, so a slot freed this cycle is reusable next cycle.
  assign w_crt_rdy  = ~w_full & ~giu_xx_async_flush;
  assign w_crt_fire = crt_req_vld & w_crt_rdy;
  assign w_ret_vld  = r_vld[w_rd_idx] & r_done[w_rd_idx] & ~giu_xx_async_flush;
  assign w_ret_fire = w_ret_vld & dcq_retire_rdy;

  assign w_one      = {{(DEPTH-1){1'b0}}, 1'b1};
  assign w_crt_oh   = w_crt_fire ? (w_one << w_wr_idx) : {DEPTH{1'b0}};
  assign w_rls_oh   = w_ret_fire ? (w_one << w_rd_idx) : {DEPTH{1'b0}};
  assign w_wb_oh    = wb_done_vld ? ((w_one << wb_done_ptr) & r_vld) : {DEPTH{1'b0}};

  xpu_vpu_pc_tn_vlsu_dcq_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk (vv_dcq_clk),
    .rst (cpurst),
    .clr (giu_xx_async_flush),
    .inc (w_crt_fire),
    .ptr (w_wr_ptr)
  );

  xpu_vpu_pc_tn_vlsu_dcq_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk (vv_dcq_clk),
    .rst (cpurst),
    .clr (giu_xx_async_flush),
    .inc (w_ret_fire),
    .ptr (w_rd_ptr)
  );

  // Per-entry bitmaps: reset > flush > retire clear > create set > wb_done set.
  always_ff @(posedge vv_dcq_clk) begin
    if (cpurst || giu_xx_async_flush) begin
      r_vld     <= {DEPTH{1'b0}};
      r_done    <= {DEPTH{1'b0}};
      r_op_last <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rls_oh[i]) begin
          r_vld[i]  <= 1'b0;
          r_done[i] <= 1'b0;
        end else if (w_crt_oh[i]) begin
          r_vld[i]     <= 1'b1;
          r_done[i]    <= crt_req_no_wb;
          r_op_last[i] <= crt_req_op_last;
        end else if (w_wb_oh[i]) begin
          r_done[i] <= 1'b1;
        end else begin
          r_done[i] <= r_done[i];
        end
      end
    end
  end

  assign crt_req_rdy         = w_crt_rdy;
  assign crt_req_ptr         = w_wr_idx;
  assign dcq_entry_crt_vld_x = w_crt_oh;
  assign dcq_entry_rls_vld_x = w_rls_oh;
  assign dcq_retire_vld      = w_ret_vld;
  assign dcq_retire_ptr      = w_rd_idx;
  assign dcq_retire_op_last  = r_op_last[w_rd_idx];
  assign dcq_full            = w_full;
  assign dcq_empty           = w_empty;
  assign dcq_cnt             = w_wr_ptr - w_rd_ptr;

`ifdef XPU_VPU_PC_TN_VLSU_DCQ_PERF_EN
  logic [XPU_VPU_PC_TN_VLSU_DCQ_PERF_W-1:0] r_perf_cnt;

  // Saturating full-stall counter; survives flush, cleared only by reset.
  always_ff @(posedge vv_dcq_clk) begin
    if (cpurst) begin
      r_perf_cnt <= {XPU_VPU_PC_TN_VLSU_DCQ_PERF_W{1'b0}};
    end else if (crt_req_vld && w_full && (r_perf_cnt != {XPU_VPU_PC_TN_VLSU_DCQ_PERF_W{1'b1}})) begin
      r_perf_cnt <= r_perf_cnt + {{(XPU_VPU_PC_TN_VLSU_DCQ_PERF_W-1){1'b0}}, 1'b1};
    end else begin
      r_perf_cnt <= r_perf_cnt;
    end
  end

  assign dcq_perf_full_stall_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_xpu_vpu_pc_tn_vlsu_dcq_ctrl.sv
// Randomized scoreboard bench for the DCQ controller with a queue-based reference model.
module tb_xpu_vpu_pc_tn_vlsu_dcq_ctrl;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             cpurst = 1'b0;
  logic             giu_xx_async_flush = 1'b0;
  logic             crt_req_vld = 1'b0;
  logic             crt_req_no_wb = 1'b0;
  logic             crt_req_op_last = 1'b0;
  logic             crt_req_rdy;
  logic [PTR_W-1:0] crt_req_ptr;
  logic [DEPTH-1:0] dcq_entry_crt_vld_x;
  logic [DEPTH-1:0] dcq_entry_rls_vld_x;
  logic             wb_done_vld = 1'b0;
  logic [PTR_W-1:0] wb_done_ptr = '0;
  logic             dcq_retire_vld;
  logic [PTR_W-1:0] dcq_retire_ptr;
  logic             dcq_retire_op_last;
  logic             dcq_retire_rdy = 1'b0;
  logic             dcq_full;
  logic             dcq_empty;
  logic [PTR_W:0]   dcq_cnt;
`ifdef XPU_VPU_PC_TN_VLSU_DCQ_PERF_EN
  logic [15:0]      dcq_perf_full_stall_cnt;
`endif

  xpu_vpu_pc_tn_vlsu_dcq_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .vv_dcq_clk          (clk),
    .cpurst              (cpurst),
    .giu_xx_async_flush  (giu_xx_async_flush),
    .crt_req_vld         (crt_req_vld),
    .crt_req_no_wb       (crt_req_no_wb),
    .crt_req_op_last     (crt_req_op_last),
    .crt_req_rdy         (crt_req_rdy),
    .crt_req_ptr         (crt_req_ptr),
    .dcq_entry_crt_vld_x (dcq_entry_crt_vld_x),
    .dcq_entry_rls_vld_x (dcq_entry_rls_vld_x),
    .wb_done_vld         (wb_done_vld),
    .wb_done_ptr         (wb_done_ptr),
    .dcq_retire_vld      (dcq_retire_vld),
    .dcq_retire_ptr      (dcq_retire_ptr),
    .dcq_retire_op_last  (dcq_retire_op_last),
    .dcq_retire_rdy      (dcq_retire_rdy),
    .dcq_full            (dcq_full),
    .dcq_empty           (dcq_empty),
    .dcq_cnt             (dcq_cnt)
`ifdef XPU_VPU_PC_TN_VLSU_DCQ_PERF_EN
    ,
    .dcq_perf_full_stall_cnt (dcq_perf_full_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PTR_W-1:0] idx;
    logic             op_last;
    logic             done;
  } ent_t;

  ent_t        mq[$];     // live entries in allocation order
  logic [3:0]  exp_q[$];  // expected retire stream {op_last, idx}
  int          alloc_n = 0;
  int          perf_m = 0;
  bit          known = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    alloc_n = 0;
  endtask

  // One cycle: drive at negedge, compare against model, then advance the model.
  task automatic step(input logic cv, input logic nw, input logic ol, input logic wv,
                      input logic [PTR_W-1:0] wp, input logic rr, input logic fl, input logic rs);
    logic             e_full, e_rdy, e_cfire, e_rvld, e_rfire;
    logic [PTR_W-1:0] e_widx, e_ridx;
    logic [DEPTH-1:0] one;
    @(negedge clk);
    crt_req_vld = cv; crt_req_no_wb = nw; crt_req_op_last = ol;
    wb_done_vld = wv; wb_done_ptr = wp; dcq_retire_rdy = rr;
    giu_xx_async_flush = fl; cpurst = rs;
    #1;
    one    = 1;
    e_full = (mq.size() == DEPTH);
    e_rdy  = !e_full && !fl;
    e_cfire = cv && e_rdy;
    e_widx = PTR_W'(alloc_n % DEPTH);
    e_ridx = (mq.size() > 0) ? mq[0].idx : e_widx;
    e_rvld = (mq.size() > 0) && mq[0].done && !fl;
    e_rfire = e_rvld && rr;
    if (known) begin
      chk("crt_req_rdy", 32'(crt_req_rdy), 32'(e_rdy));
      chk("dcq_full", 32'(dcq_full), 32'(e_full));
      chk("dcq_empty", 32'(dcq_empty), 32'(mq.size() == 0));
      chk("dcq_cnt", 32'(dcq_cnt), 32'(mq.size()));
      chk("retire_vld", 32'(dcq_retire_vld), 32'(e_rvld));
      chk("crt_vld_x", 32'(dcq_entry_crt_vld_x), e_cfire ? 32'(one << e_widx) : 32'd0);
      chk("rls_vld_x", 32'(dcq_entry_rls_vld_x), e_rfire ? 32'(one << e_ridx) : 32'd0);
      if (e_cfire) chk("crt_req_ptr", 32'(crt_req_ptr), 32'(e_widx));
`ifdef XPU_VPU_PC_TN_VLSU_DCQ_PERF_EN
      chk("perf_cnt", 32'(dcq_perf_full_stall_cnt), 32'(perf_m));
`endif
    end
    if (rs) begin
      model_clear();
      perf_m = 0;
      known = 1'b1;
    end else begin
      if (cv && e_full && perf_m < 16'hFFFF) perf_m++;
      if (fl) begin
        model_clear();
      end else begin
        if (wv) foreach (mq[k]) if (mq[k].idx == wp) mq[k].done = 1'b1;
        if (e_rfire) void'(mq.pop_front());
        if (e_cfire) begin
          mq.push_back('{idx: e_widx, op_last: ol, done: nw});
          exp_q.push_back({ol, e_widx});
          alloc_n++;
        end
      end
    end
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, rr, 1'b0, 1'b0);
  endtask

  // Retire monitor: pops the expected stream whenever the DUT hands an entry to commit.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (known && !cpurst && dcq_retire_vld === 1'b1 && dcq_retire_rdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL retire_unexpected actual_ptr=%0d required=none", dcq_retire_ptr);
        end else begin
          e = exp_q.pop_front();
          chk("retire_ptr", 32'(dcq_retire_ptr), 32'(e[PTR_W-1:0]));
          chk("retire_op_last", 32'(dcq_retire_op_last), 32'(e[3]));
        end
      end
    end
  end

  initial begin
    logic [PTR_W-1:0] wp;
    // Reset and fill with write-back pending entries.
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'(i & 1), 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("full_after_fill", 32'(dcq_full), 32'd1);
    chk("cnt_after_fill", 32'(dcq_cnt), 32'd8);
    // Out-of-order write-backs, then full-queue retire with a stalled create.
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    // no_wb create into an empty queue retires on the next cycle.
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    // Flush with five entries, two done; stale wb_done afterwards is ignored.
    for (int i = 0; i < 5; i++) step(1'b1, 1'(i < 2), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
`ifdef XPU_VPU_PC_TN_VLSU_DCQ_PERF_EN
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk("perf_after_flush", 32'(dcq_perf_full_stall_cnt), 32'd20);
`endif
    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      if (mq.size() > 0 && $urandom_range(0, 1) == 0)
        wp = mq[$urandom_range(0, mq.size() - 1)].idx;
      else
        wp = PTR_W'($urandom_range(0, DEPTH - 1));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), wp, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 399) == 0));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xpu_vpu_pc_tn_vlsu_dcq_ctrl.md
# xpu_vpu_pc_tn_vlsu_dcq_ctrl

Allocation and in-order release controller for the VLSU data commit queue (DCQ). It owns the queue pointers and per-entry create/release strobes that drive the DCQ entry array. It tracks each entry's write-back completion and retires entries strictly in allocation order. It sits between the VLSU uop issue stage (create side) and the VLSU write-back/commit logic (retire side).

## Interface
- DEPTH, 8, number of DCQ entries; power of two, 2..16
- PTR_W, $clog2(DEPTH), entry index width
- vv_dcq_clk  in  1  DCQ clock
- cpurst  in  1  reset, synchronous, active-high
- giu_xx_async_flush  in  1  flush all entries
- crt_req_vld  in  1  uop requests a DCQ entry
- crt_req_no_wb  in  1  uop needs no write-back (entry complete at create)
- crt_req_op_last  in  1  last uop of the instruction
- crt_req_rdy  out  1  entry can be allocated this cycle
- crt_req_ptr  out  PTR_W  index allocated on create fire
- dcq_entry_crt_vld_x  out  DEPTH  one-hot create strobe to entry array
- dcq_entry_rls_vld_x  out  DEPTH  one-hot release strobe to entry array
- wb_done_vld  in  1  write-back finished for one entry
- wb_done_ptr  in  PTR_W  entry index of finished write-back
- dcq_retire_vld  out  1  head entry is complete and may retire
- dcq_retire_ptr  out  PTR_W  head entry index
- dcq_retire_op_last  out  1  op_last of head entry
- dcq_retire_rdy  in  1  commit logic accepts head
- dcq_full  out  1  all entries allocated
- dcq_empty  out  1  no entries allocated
- dcq_cnt  out  PTR_W+1  allocated entry count

## Operation
- Pointers: wr_ptr and rd_ptr are PTR_W+1 bits wide, with the MSB as the wrap bit. empty = (wr_ptr == rd_ptr). full = index bits equal and wrap bits differ. dcq_cnt = wr_ptr - rd_ptr, taken modulo 2^(PTR_W+1).
- Per-entry state: vld[DEPTH], done[DEPTH], op_last[DEPTH].
- crt_req_rdy = ~dcq_full & ~giu_xx_async_flush. It uses registered full, so there is no same-cycle reuse of a slot being retired.
- Create fire (vld & rdy):
  - dcq_entry_crt_vld_x[wr_idx] = 1.
  - Next cycle: vld = 1, done = crt_req_no_wb, op_last = crt_req_op_last, wr_ptr + 1.
- wb_done_vld sets done[wb_done_ptr] only if vld[wb_done_ptr] = 1. Otherwise it is ignored. A duplicate wb_done to an already-done entry is a no-op.
- dcq_retire_vld = vld[rd_idx] & done[rd_idx] & ~giu_xx_async_flush.
- Retire fire (retire_vld & retire_rdy):
  - dcq_entry_rls_vld_x[rd_idx] = 1.
  - Next cycle: vld/done of that entry cleared, rd_ptr + 1.
- Simultaneous create and retire: both take effect, and dcq_cnt is unchanged.
- Simultaneous wb_done and retire on the head: wb_done is ignored because the entry is already done.
- giu_xx_async_flush: in the same cycle, rdy = 0 and retire_vld = 0, and no crt/rls strobes are issued. Next cycle: all vld/done/op_last = 0 and wr_ptr = rd_ptr = 0. The entry array clears its own state from the same flush input.
- Reset: same effect as flush. After reset, crt_req_rdy = 1, dcq_empty = 1, all other outputs = 0.

## Timing
- Strobes (crt_vld_x, rls_vld_x) are combinational from the fire condition in the same cycle. They are intended for the entry registers on the next edge.
- Create to earliest retire:
  - no_wb entry: retire_vld 1 cycle after create fire, if it is at the head.
  - Otherwise: 1 cycle after wb_done_vld.
- Throughput: one create and one retire per cycle.
- All state registers update on posedge vv_dcq_clk. cpurst is sampled at the edge and takes priority over flush and all other updates.
- Priority per entry: reset > flush > retire clear > create set > wb_done set.

## Configuration
- XPU_VPU_PC_TN_VLSU_DCQ_PERF_EN defined: adds output dcq_perf_full_stall_cnt [15:0].
  - Increments each cycle that crt_req_vld & dcq_full, and saturates at 16'hFFFF.
  - Cleared by cpurst only, not by flush.
- Undefined: port and counter are absent. All other behaviour is identical.

## Structure
- Shared package/defines hold the DCQ constants:
  - XPU_VPU_PC_TN_VLSU_DCQ_DEPTH
  - XPU_VPU_PC_TN_VLSU_DCQ_PTR_W
  - the perf counter width
- One sub-module is natural: xpu_vpu_pc_tn_vlsu_dcq_ptr, a wrap-bit pointer with inc and clear. It is instantiated twice (wr, rd).
- Bitmaps and one-hot decode stay in the top.

## Test plan
- Reset, then 8 creates with no_wb = 0, no wb_done: crt_req_ptr goes 0..7. After the 8th, dcq_full = 1, crt_req_rdy = 0, dcq_cnt = 8, and retire_vld stays 0.
- Out-of-order wb_done to ptr 2, then 1, then 0, with retire_rdy = 1: retire occurs only after ptr 0 is done, then 0, 1, 2 retire on consecutive cycles. rls_vld_x = 8'h01, 8'h02, 8'h04.
- Create with no_wb = 1 into an empty queue: retire_vld = 1 on the next cycle with ptr 0 and the matching op_last.
- Full queue, head done, retire and a create request in the same cycle: retire fires, create is stalled. Next cycle create fires into freed slot 0 (wrap bit toggled), and dcq_cnt returns to 8.
- Flush with 5 entries allocated, 2 of them done: retire_vld = 0 and rdy = 0 that cycle. Next cycle dcq_empty = 1, cnt = 0, and ptrs are 0. A wb_done to old ptr 3 is ignored.
- PERF_EN: hold crt_req_vld with the queue full for 20 cycles. dcq_perf_full_stall_cnt = 20, and a flush leaves it at 20.
